regfile_dump: RTL and testbench
===============================

Name: regfile_dump

Overview:
- RV32I 32x32 general-purpose register file built from the team's load/reset register semantics.
- Write port uses active-low load; x0 is hardwired to zero.
- Provides two combinational read ports with write-through bypass for the decode stage.
- Adds a read-out engine that streams all 32 registers over a valid/ready handshake to the debug/trace path, so the reader side of the register array is owned by one block.

Parameters:
- DataWidth, 32, register width in bits.
- NumRegs, 32, number of architectural registers; must be a power of 2.
- AddrWidth, 5, index width; must equal log2(NumRegs).

Ports:
- Clk  input  1  clock; all state updates on the falling edge.
- Reset  input  1  synchronous, active-low reset.
- WrLD  input  1  write strobe, active-low; writes Din to WrAddr at the falling edge.
- WrAddr  input  AddrWidth  write index.
- Din  input  DataWidth  write data.
- RdAddrA  input  AddrWidth  read port A index.
- RdDataA  output  DataWidth  read port A data, combinational.
- RdAddrB  input  AddrWidth  read port B index.
- RdDataB  output  DataWidth  read port B data, combinational.
- DumpReq  input  1  active-high request to start a full dump; sampled only in IDLE.
- DumpValid  output  1  DumpData/DumpIdx hold a valid beat.
- DumpReady  input  1  consumer accepts the beat when high together with DumpValid at a falling edge.
- DumpIdx  output  AddrWidth  index of the current beat.
- DumpData  output  DataWidth  contents of register DumpIdx, registered.
- DumpBusy  output  1  high in SEND state.
- DumpDone  output  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (synchronous, active-low, falling edge):
  - all NumRegs entries cleared to 0;
  - FSM forced to IDLE;
  - DumpValid=0, DumpIdx=0, DumpData=0, DumpBusy=0, DumpDone=0.
  - Reset wins over WrLD and DumpReq in the same cycle, and aborts a dump in progress with no DumpDone.
- Write:
  - WrLD=0 at a falling edge stores Din into entry WrAddr.
  - WrAddr=0 is ignored; entry 0 always reads 0.
  - WrLD=1: contents hold.
- Read (combinational):
  - RdAddr=0 returns 0.
  - If WrLD=0, WrAddr==RdAddr and WrAddr!=0, Din is returned (bypass).
  - Otherwise the stored entry is returned.
  - Both ports are independent and may read the same index.
- Dump FSM states: IDLE, SEND, DONE.
  - IDLE: DumpReq=1 -> SEND; DumpIdx=0, DumpData=0 (x0), DumpValid=1, DumpBusy=1.
  - SEND, DumpValid & DumpReady at the edge:
    - if DumpIdx==NumRegs-1 -> DONE; DumpValid=0.
    - else DumpIdx+1, DumpData loads the entry at DumpIdx+1, DumpValid stays 1.
  - SEND, DumpReady=0: DumpIdx and DumpData held stable; DumpValid stays 1.
  - DONE: DumpDone=1 for exactly one cycle, DumpBusy=0, then -> IDLE.
  - DumpReq outside IDLE is ignored (no queueing).
- Dump coherency:
  - Each beat's data is loaded when the beat is launched.
  - A write committed to index k at the same edge the beat for k is loaded: the beat carries Din (bypass applied to the dump read).
  - Writes to k after its beat launched are not reflected in the dump.
  - Writes to indices not yet sent appear in their beats.
- Dump throughput: 1 beat per cycle with DumpReady held high.
  - Full dump = 32 beats, first DumpValid one cycle after DumpReq.
  - DumpDone asserted in the cycle after the final handshake.
- Read ports are unaffected by dump activity.
- Under SIMULATE, display time plus index/data on every write and every accepted dump beat.

Test Plan:
- Reset, then WrLD=0 WrAddr=5 Din=0xDEADBEEF, then WrLD=1 -> RdAddrA=5 returns 0xDEADBEEF; RdAddrB=6 returns 0.
- WrLD=0 WrAddr=0 Din=0xFFFFFFFF -> RdDataA with RdAddrA=0 stays 0 before and after the edge; dump beat 0 = 0.
- Bypass: WrLD=0 WrAddr=7 Din=0x12345678 with RdAddrA=RdAddrB=7 in the same cycle -> both read 0x12345678 before the edge.
- Dump with DumpReady=1 after writing x_i=i*0x11 for i=1..31:
  - 32 beats, DumpIdx 0..31, DumpData i*0x11 (beat 0 = 0);
  - DumpDone pulses once, 33 cycles after DumpReq.
- Dump with DumpReady toggled 1,0,0,1: beats held stable while low, no index skipped or repeated; write x20=0xA5A5A5A5 at beat 10 -> beat 20 carries 0xA5A5A5A5.
- Reset asserted at beat 12 -> DumpValid=0, DumpBusy=0 next edge, no DumpDone, all registers read 0.

Source files
------------

// File: rtl/regfile_dump.sv
// regfile_dump: RV32I register file with bypassed read ports and a handshaked full-register dump engine
module regfile_dump #(
  parameter int DataWidth = 32,
  parameter int NumRegs   = 32,
  parameter int AddrWidth = 5
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 WrLD,
  input  logic [AddrWidth-1:0] WrAddr,
  input  logic [DataWidth-1:0] Din,
  input  logic [AddrWidth-1:0] RdAddrA,
  output logic [DataWidth-1:0] RdDataA,
  input  logic [AddrWidth-1:0] RdAddrB,
  output logic [DataWidth-1:0] RdDataB,
  input  logic                 DumpReq,
  output logic                 DumpValid,
  input  logic                 DumpReady,
  output logic [AddrWidth-1:0] DumpIdx,
  output logic [DataWidth-1:0] DumpData,
  output logic                 DumpBusy,
  output logic                 DumpDone
);
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
  localparam logic [AddrWidth-1:0] Last = AddrWidth'(NumRegs - 1);
  state_t state_q, state_d;
  logic [DataWidth-1:0] regs_q [NumRegs];
  logic [AddrWidth-1:0] idx_q, idx_d, nxt_idx;
  logic [DataWidth-1:0] data_q, data_d, nxt_data;
  logic wr;
  assign wr       = !WrLD && WrAddr != '0;
  assign nxt_idx  = idx_q + 1'b1;
  assign RdDataA  = RdAddrA == '0 ? '0 : (wr && WrAddr == RdAddrA) ? Din : regs_q[RdAddrA];
  assign RdDataB  = RdAddrB == '0 ? '0 : (wr && WrAddr == RdAddrB) ? Din : regs_q[RdAddrB];
  assign nxt_data = (wr && WrAddr == nxt_idx) ? Din : regs_q[nxt_idx];
  assign DumpValid = state_q == SEND;
  assign DumpBusy  = state_q == SEND;
  assign DumpDone  = state_q == DONE;
  assign DumpIdx   = idx_q;
  assign DumpData  = data_q;
  always_ff @(negedge Clk)
    if (!Reset) for (int i = 0; i < NumRegs; i++) regs_q[i] <= '0;
    else if (wr) regs_q[WrAddr] <= Din;
  always_ff @(negedge Clk)
    if (!Reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: if (DumpReq) begin
        state_d = SEND;
        idx_d   = '0;
        data_d  = '0;
      end
      SEND: if (DumpReady) begin
        if (idx_q == Last) state_d = DONE;
        else begin
          idx_d  = nxt_idx;
          data_d = nxt_data;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
`ifdef SIMULATE
  always @(negedge Clk) begin
    if (Reset && wr) $display("%0t write x%0d = %h", $time, WrAddr, Din);
    if (Reset && DumpValid && DumpReady) $display("%0t dump x%0d = %h", $time, DumpIdx, DumpData);
  end
`endif
endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: directed self-checking bench for regfile_dump
module tb_regfile_dump;
  logic        Clk, Reset, WrLD, DumpReq, DumpReady;
  logic [4:0]  WrAddr, RdAddrA, RdAddrB, DumpIdx;
  logic [31:0] Din, RdDataA, RdDataB, DumpData;
  logic        DumpValid, DumpBusy, DumpDone;
  logic [31:0] exp_q [32];
  int pass_cnt = 0;
  int total = 0;
  regfile_dump dut (
    .Clk(Clk), .Reset(Reset), .WrLD(WrLD), .WrAddr(WrAddr), .Din(Din),
    .RdAddrA(RdAddrA), .RdDataA(RdDataA), .RdAddrB(RdAddrB), .RdDataB(RdDataB),
    .DumpReq(DumpReq), .DumpValid(DumpValid), .DumpReady(DumpReady),
    .DumpIdx(DumpIdx), .DumpData(DumpData), .DumpBusy(DumpBusy), .DumpDone(DumpDone)
  );
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  task automatic tick;
    @(negedge Clk);
    #1;
  endtask
  task automatic test_reset;
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    RdAddrA = 5'd3;
    #1;
    total++; if ({DumpValid, DumpBusy, DumpDone} !== 3'b000) $display("FAIL reset_flags got %b want 000", {DumpValid, DumpBusy, DumpDone}); else pass_cnt++;
    total++; if (DumpIdx !== 5'd0) $display("FAIL reset_idx got %0d want 0", DumpIdx); else pass_cnt++;
    total++; if (DumpData !== 32'd0) $display("FAIL reset_data got %h want 0", DumpData); else pass_cnt++;
    total++; if (RdDataA !== 32'd0) $display("FAIL reset_reg got %h want 0", RdDataA); else pass_cnt++;
  endtask
  task automatic test_write;
    WrLD = 1'b0; WrAddr = 5'd5; Din = 32'hDEADBEEF;
    tick();
    WrLD = 1'b1; RdAddrA = 5'd5; RdAddrB = 5'd6;
    #1;
    total++; if (RdDataA !== 32'hDEADBEEF) $display("FAIL write_a got %h want deadbeef", RdDataA); else pass_cnt++;
    total++; if (RdDataB !== 32'd0) $display("FAIL write_b got %h want 0", RdDataB); else pass_cnt++;
    Din = 32'h0BADF00D;
    tick();
    total++; if (RdDataA !== 32'hDEADBEEF) $display("FAIL write_hold got %h want deadbeef", RdDataA); else pass_cnt++;
  endtask
  task automatic test_x0;
    RdAddrA = 5'd0; WrLD = 1'b0; WrAddr = 5'd0; Din = 32'hFFFFFFFF;
    #1;
    total++; if (RdDataA !== 32'd0) $display("FAIL x0_before got %h want 0", RdDataA); else pass_cnt++;
    tick();
    WrLD = 1'b1;
    #1;
    total++; if (RdDataA !== 32'd0) $display("FAIL x0_after got %h want 0", RdDataA); else pass_cnt++;
  endtask
  task automatic test_bypass;
    WrLD = 1'b0; WrAddr = 5'd7; Din = 32'h12345678; RdAddrA = 5'd7; RdAddrB = 5'd7;
    #1;
    total++; if (RdDataA !== 32'h12345678) $display("FAIL bypass_a got %h want 12345678", RdDataA); else pass_cnt++;
    total++; if (RdDataB !== 32'h12345678) $display("FAIL bypass_b got %h want 12345678", RdDataB); else pass_cnt++;
    tick();
    WrLD = 1'b1;
    #1;
    total++; if (RdDataB !== 32'h12345678) $display("FAIL bypass_store got %h want 12345678", RdDataB); else pass_cnt++;
  endtask
  task automatic test_dump_full;
    int edges;
    exp_q[0] = 32'd0;
    for (int i = 1; i < 32; i++) begin
      WrLD = 1'b0; WrAddr = 5'(i); Din = 32'(i * 'h11); exp_q[i] = 32'(i * 'h11);
      tick();
    end
    WrLD = 1'b1; DumpReady = 1'b1; DumpReq = 1'b1;
    tick();
    DumpReq = 1'b0;
    edges = 1;
    for (int i = 0; i < 32; i++) begin
      total++; if (!DumpValid || DumpIdx !== 5'(i) || DumpData !== exp_q[i]) $display("FAIL full_beat%0d got v=%b idx=%0d data=%h want v=1 idx=%0d data=%h", i, DumpValid, DumpIdx, DumpData, i, exp_q[i]); else pass_cnt++;
      tick();
      edges++;
    end
    total++; if (DumpDone !== 1'b1 || DumpValid !== 1'b0 || DumpBusy !== 1'b0) $display("FAIL full_done got done=%b v=%b busy=%b want 1 0 0 after %0d edges", DumpDone, DumpValid, DumpBusy, edges); else pass_cnt++;
    total++; if (edges !== 33) $display("FAIL full_latency got %0d want 33", edges); else pass_cnt++;
    tick();
    total++; if (DumpDone !== 1'b0 || DumpValid !== 1'b0) $display("FAIL full_pulse got done=%b v=%b want 0 0", DumpDone, DumpValid); else pass_cnt++;
  endtask
  task automatic test_dump_stall;
    logic [3:0] pat;
    logic acc, wr, wrote;
    int e;
    pat = 4'b1001; e = 0; wrote = 1'b0;
    DumpReq = 1'b1; DumpReady = 1'b0;
    tick();
    DumpReq = 1'b0;
    for (int c = 0; c < 400; c++) begin
      DumpReady = pat[c % 4];
      wr = (e == 10) && !wrote;
      if (wr) begin WrLD = 1'b0; WrAddr = 5'd20; Din = 32'hA5A5A5A5; end
      total++; if (!DumpValid || DumpIdx !== 5'(e) || DumpData !== exp_q[e]) $display("FAIL stall_c%0d got v=%b idx=%0d data=%h want v=1 idx=%0d data=%h", c, DumpValid, DumpIdx, DumpData, e, exp_q[e]); else pass_cnt++;
      acc = DumpReady;
      tick();
      WrLD = 1'b1;
      if (wr) begin exp_q[20] = 32'hA5A5A5A5; wrote = 1'b1; end
      if (acc) e++;
      if (e == 32) break;
    end
    total++; if (e !== 32 || DumpDone !== 1'b1) $display("FAIL stall_done got beats=%0d done=%b want 32 1", e, DumpDone); else pass_cnt++;
    DumpReady = 1'b1;
    tick();
  endtask
  task automatic test_reset_abort;
    logic bad;
    DumpReady = 1'b1; DumpReq = 1'b1;
    tick();
    DumpReq = 1'b0;
    repeat (12) tick();
    total++; if (DumpIdx !== 5'd12 || DumpData !== exp_q[12]) $display("FAIL abort_pre got idx=%0d data=%h want 12 %h", DumpIdx, DumpData, exp_q[12]); else pass_cnt++;
    Reset = 1'b0; WrLD = 1'b0; WrAddr = 5'd3; Din = 32'h55555555; DumpReq = 1'b1;
    tick();
    Reset = 1'b1; WrLD = 1'b1; DumpReq = 1'b0;
    total++; if ({DumpValid, DumpBusy, DumpDone} !== 3'b000 || DumpIdx !== 5'd0) $display("FAIL abort_now got v/b/d=%b idx=%0d want 000 0", {DumpValid, DumpBusy, DumpDone}, DumpIdx); else pass_cnt++;
    tick();
    total++; if (DumpDone !== 1'b0 || DumpValid !== 1'b0) $display("FAIL abort_next got done=%b v=%b want 0 0", DumpDone, DumpValid); else pass_cnt++;
    bad = 1'b0;
    for (int i = 0; i < 32; i++) begin
      RdAddrA = 5'(i); RdAddrB = 5'(31 - i);
      #1;
      if (RdDataA !== 32'd0 || RdDataB !== 32'd0) bad = 1'b1;
    end
    total++; if (bad !== 1'b0) $display("FAIL abort_regs got nonzero register want all 0"); else pass_cnt++;
  endtask
  initial begin
    Reset = 1'b0; WrLD = 1'b1; WrAddr = '0; Din = '0; RdAddrA = '0; RdAddrB = '0;
    DumpReq = 1'b0; DumpReady = 1'b0;
    test_reset();
    test_write();
    test_x0();
    test_bypass();
    test_dump_full();
    test_dump_stall();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
